// File: rtl/zbt_port_arbiter_pkg.sv
// Shared widths, port indices and read-tag payload for the ZBT port arbiter.
package zbt_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 36;
    localparam int unsigned PORT_W = 2;

    localparam logic [PORT_W-1:0] PORT_DISP  = PORT_W'(0);
    localparam logic [PORT_W-1:0] PORT_EDGE  = PORT_W'(1);
    localparam logic [PORT_W-1:0] PORT_WRITE = PORT_W'(2);

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } read_tag_t;

endpackage

// File: rtl/zbt_port_arbiter_if.sv
// Requester and memory-side signals of the ZBT port arbiter.
interface zbt_port_arbiter_if;
    import zbt_port_arbiter_pkg::*;

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;

    logic              req2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata2;
    logic              gnt2;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, addr0, req1, addr1, req2, addr2, wdata2, mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, gnt2, rdata,
               mem_addr, mem_we, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output req0, addr0, req1, addr1, req2, addr2, wdata2, mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, gnt2, rdata,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/zbt_port_arbiter_read_tag_pipe.sv
// Fixed-depth shift register of read tags, aligned with the ZBT read pipeline.
module zbt_port_arbiter_read_tag_pipe
    import zbt_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      clr,
    input  read_tag_t tag_in,
    output read_tag_t tag_out
);

    read_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT SRAM port between display read, edge-detector read and
// edge-map write; one memory op per cycle, read data routed back by tag.
module zbt_port_arbiter
    import zbt_port_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned DISP_BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    zbt_port_arbiter_if.slave bus
);

    localparam int unsigned BURST_W = $clog2(DISP_BURST + 1);

    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_nxt;
    logic               rr_edge;
    logic               rr_edge_nxt;
    logic               gnt0;
    logic               gnt1;
    logic               gnt2;
    logic               others;
    logic               burst_hit;
    logic [ADDR_W-1:0]  sel_addr;
    read_tag_t          issue_tag;
    read_tag_t          issue_tag_nxt;
    read_tag_t          ret_tag;

    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_we_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic               rvalid0_q;
    logic               rvalid1_q;
    logic [DATA_W-1:0]  rdata_q;

    assign others    = bus.req1 | bus.req2;
    assign burst_hit = others && (burst_cnt == BURST_W'(DISP_BURST));

    // Grant selection: display first unless its burst allowance is used up
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        gnt2          = 1'b0;
        sel_addr      = bus.addr0;
        issue_tag_nxt = '0;
        if (!reset) begin
            if (bus.req0 && !burst_hit) begin
                gnt0 = 1'b1;
            end else if (bus.req1 && (rr_edge || !bus.req2)) begin
                gnt1 = 1'b1;
            end else if (bus.req2) begin
                gnt2 = 1'b1;
            end
        end
        if (gnt1) begin
            sel_addr = bus.addr1;
        end else if (gnt2) begin
            sel_addr = bus.addr2;
        end
        issue_tag_nxt.valid = gnt0 | gnt1;
        issue_tag_nxt.port  = gnt1 ? PORT_EDGE : PORT_DISP;
    end

    // Burst counter and round-robin pointer next state
    always_comb begin
        burst_cnt_nxt = burst_cnt;
        rr_edge_nxt   = rr_edge;
        if (gnt1 || gnt2 || !others) begin
            burst_cnt_nxt = '0;
        end else if (gnt0 && (burst_cnt != BURST_W'(DISP_BURST))) begin
            burst_cnt_nxt = burst_cnt + BURST_W'(1);
        end
        if (gnt1) begin
            rr_edge_nxt = 1'b0;
        end else if (gnt2) begin
            rr_edge_nxt = 1'b1;
        end
    end

    // Arbitration state and issue stage
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt   <= '0;
            rr_edge     <= 1'b1;
            issue_tag   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
            rr_edge   <= rr_edge_nxt;
            issue_tag <= issue_tag_nxt;
            mem_we_q  <= gnt2;
            if (gnt0 || gnt1 || gnt2) begin
                mem_addr_q <= sel_addr;
            end
            if (gnt2) begin
                mem_wdata_q <= bus.wdata2;
            end
        end
    end

    // Tag emerges in the same cycle as the matching mem_rdata
    zbt_port_arbiter_read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_tag_pipe (
        .clk     (clk),
        .clr     (reset),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    // Read return stage
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid0_q <= ret_tag.valid && (ret_tag.port == PORT_DISP);
            rvalid1_q <= ret_tag.valid && (ret_tag.port == PORT_EDGE);
            if (ret_tag.valid) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.gnt2      = gnt2;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata     = rdata_q;

endmodule
